// File: rtl/mult_div_if.sv
// Operand/strobe bundle between the EX-stage controller and the multiply/divide unit.
interface mult_div_if;
    logic        start;
    logic [2:0]  op;
    logic        mthi;
    logic        mtlo;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, op, mthi, mtlo, a, b, input busy, hi, lo);
    modport slave  (input start, op, mthi, mtlo, a, b, output busy, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// Fixed-latency multiply/divide unit holding the architectural HI/LO registers.
//   state | meaning
//   IDLE  | no operation in flight, mthi/mtlo accepted, busy=0
//   RUN   | cnt counts down the latency, result commits when cnt==1, busy=1
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    mult_div_if.slave  bus
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [1:0]    op_q, op_nx;
    logic [31:0]   a_q, a_nx, b_q, b_nx;
    logic [31:0]   hi_q, hi_nx, lo_q, lo_nx;

    logic          launch;
    logic [63:0]   prod_s, prod_u;
    logic          is_divu;
    logic [31:0]   abs_a, abs_b, div_n, div_d, uq, ur, quo, rem;

    // Products from 64-bit extended operands; the low 64 bits are exact for both signednesses.
    assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

    // Signed divide goes through magnitudes so 0x80000000 / -1 wraps to 0x80000000 naturally.
    assign is_divu = op_q[0];
    assign abs_a   = a_q[31] ? (32'd0 - a_q) : a_q;
    assign abs_b   = b_q[31] ? (32'd0 - b_q) : b_q;
    assign div_n   = is_divu ? a_q : abs_a;
    assign div_d   = (b_q == 32'd0) ? 32'd1 : (is_divu ? b_q : abs_b);
    assign uq      = div_n / div_d;
    assign ur      = div_n % div_d;
    assign quo     = (!is_divu && (a_q[31] ^ b_q[31])) ? (32'd0 - uq) : uq;
    assign rem     = (!is_divu && a_q[31]) ? (32'd0 - ur) : ur;

    assign launch  = bus.start && !bus.op[2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            op_q  <= op_nx;
            a_q   <= a_nx;
            b_q   <= b_nx;
            hi_q  <= hi_nx;
            lo_q  <= lo_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        op_nx    = op_q;
        a_nx     = a_q;
        b_nx     = b_q;
        hi_nx    = hi_q;
        lo_nx    = lo_q;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (launch) begin
                        op_nx    = bus.op[1:0];
                        a_nx     = bus.a;
                        b_nx     = bus.b;
                        cnt_nx   = bus.op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                        state_nx = RUN;
                    end
                end else begin
                    if (bus.mthi) hi_nx = bus.a;
                    if (bus.mtlo) lo_nx = bus.a;
                end
            end
            RUN: begin
                cnt_nx = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_nx = IDLE;
                    if (!op_q[1]) begin
                        hi_nx = is_divu ? prod_u[63:32] : prod_s[63:32];
                        lo_nx = is_divu ? prod_u[31:0]  : prod_s[31:0];
                    end else if (b_q != 32'd0) begin
                        hi_nx = rem;
                        lo_nx = quo;
                    end
                    // A start on the commit edge is taken straight back into RUN.
                    if (launch) begin
                        op_nx    = bus.op[1:0];
                        a_nx     = bus.a;
                        b_nx     = bus.b;
                        cnt_nx   = bus.op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                        state_nx = RUN;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.busy = (state == RUN);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and randomized checks of mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [31:0] exp_hi = '0, exp_lo = '0;

    mult_div_if bus();
    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_hi"}, bus.hi, exp_hi);
        check({tag, "_lo"}, bus.lo, exp_lo);
    endtask

    // Architectural effect of one completed operation on HI/LO.
    task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        longint unsigned ux, uy, p;
        sx = $signed(x);
        sy = $signed(y);
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (o)
            3'd0: begin p = sx * sy; exp_hi = p[63:32]; exp_lo = p[31:0]; end
            3'd1: begin p = ux * uy; exp_hi = p[63:32]; exp_lo = p[31:0]; end
            3'd2: if (y != 0) begin q = sx / sy; r = sx - q * sy; exp_lo = q[31:0]; exp_hi = r[31:0]; end
            3'd3: if (y != 0) begin exp_lo = x / y; exp_hi = x % y; end
            default: ;
        endcase
    endtask

    function automatic int latency(input logic [2:0] o);
        return o[1] ? 10 : 5;
    endfunction

    // Drive a start for one cycle; returns at the falling edge after the sampling edge.
    task automatic launch(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic m_hi, input logic m_lo);
        bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y; bus.mthi = m_hi; bus.mtlo = m_lo;
        @(negedge clk);
        bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
        bus.a = $urandom; bus.b = $urandom;
    endtask

    task automatic wait_done(input int n, input string tag);
        int c = 0;
        while (bus.busy === 1'b1 && c < 1000) begin
            c++;
            @(negedge clk);
        end
        check(tag, 32'(c), 32'(n));
    endtask

    task automatic move_to(input logic m_hi, input logic m_lo, input logic [31:0] x);
        bus.mthi = m_hi; bus.mtlo = m_lo; bus.a = x;
        @(negedge clk);
        bus.mthi = 1'b0; bus.mtlo = 1'b0;
        if (m_hi) exp_hi = x;
        if (m_lo) exp_lo = x;
    endtask

    initial begin
        logic [2:0]  o;
        logic [31:0] x, y, x2, y2;
        logic        mh, ml;

        bus.start = 1'b0; bus.op = 3'd0; bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.a = '0; bus.b = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check_regs("rst");
        reset = 1'b0;
        @(negedge clk);

        move_to(1'b1, 1'b0, 32'h1234_5678);
        check("mthi_hi", bus.hi, 32'h1234_5678);
        check("mthi_lo", bus.lo, 32'h0);
        check("mthi_busy", {31'd0, bus.busy}, 32'd0);

        launch(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
        wait_done(5, "mult_cycles");
        model(3'd0, 32'hFFFF_FFFE, 32'd3);
        check_regs("mult");
        check("mult_lit_hi", bus.hi, 32'hFFFF_FFFF);
        check("mult_lit_lo", bus.lo, 32'hFFFF_FFFA);

        launch(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
        wait_done(5, "multu_cycles");
        model(3'd1, 32'hFFFF_FFFE, 32'd3);
        check_regs("multu");
        check("multu_lit_hi", bus.hi, 32'h0000_0002);

        launch(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        wait_done(10, "div_cycles");
        model(3'd2, 32'hFFFF_FFF9, 32'd2);
        check_regs("div");
        check("div_lit_lo", bus.lo, 32'hFFFF_FFFD);
        check("div_lit_hi", bus.hi, 32'hFFFF_FFFF);

        launch(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        wait_done(10, "divovf_cycles");
        model(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        check_regs("divovf");
        check("divovf_lit_lo", bus.lo, 32'h8000_0000);

        move_to(1'b1, 1'b0, 32'hAA);
        move_to(1'b0, 1'b1, 32'hBB);
        launch(3'd3, 32'h1234, 32'd0, 1'b0, 1'b0);
        wait_done(10, "divz_cycles");
        check("divz_hi", bus.hi, 32'hAA);
        check("divz_lo", bus.lo, 32'hBB);

        // Disturbances during RUN, then a back-to-back start on the commit edge.
        x = 32'h0001_2345; y = 32'hFFFF_0003;
        launch(3'd0, x, y, 1'b0, 1'b0);
        bus.start = 1'b1; bus.op = 3'd2; bus.a = 32'h5; bus.b = 32'h7; bus.mtlo = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.mtlo = 1'b0;
        check("run_mtlo_lo", bus.lo, exp_lo);
        repeat (3) @(negedge clk);
        check("run_busy_e4", {31'd0, bus.busy}, 32'd1);
        check_regs("run_nopartial");
        x2 = 32'h89AB_CDEF; y2 = 32'h0000_1001;
        bus.start = 1'b1; bus.op = 3'd1; bus.a = x2; bus.b = y2;
        @(negedge clk);
        bus.start = 1'b0;
        model(3'd0, x, y);
        check_regs("run_orig");
        check("b2b_busy", {31'd0, bus.busy}, 32'd1);
        wait_done(5, "b2b_cycles");
        model(3'd1, x2, y2);
        check_regs("b2b");

        // Reset during the third busy cycle of a divide.
        launch(3'd3, 32'd1000, 32'd7, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        exp_hi = '0; exp_lo = '0;
        check("rstrun_busy", {31'd0, bus.busy}, 32'd0);
        check_regs("rstrun");
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        check("rstrun_after_busy", {31'd0, bus.busy}, 32'd0);
        check_regs("rstrun_after");

        for (int i = 0; i < 60; i++) begin
            x  = $urandom;
            y  = $urandom;
            if ($urandom_range(0, 5) == 0) y = 32'd0;
            if ($urandom_range(0, 9) == 0) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
            o  = 3'($urandom_range(0, 7));
            mh = 1'($urandom_range(0, 1));
            ml = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) begin
                move_to(mh, ml, x);
                check("rnd_mv_busy", {31'd0, bus.busy}, 32'd0);
                check_regs("rnd_mv");
            end else if (o[2]) begin
                launch(o, x, y, mh, ml);
                check("rnd_rsv_busy", {31'd0, bus.busy}, 32'd0);
                check_regs("rnd_rsv");
            end else begin
                launch(o, x, y, mh, ml);
                wait_done(latency(o), "rnd_cycles");
                model(o, x, y);
                check_regs("rnd_op");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multiply/divide responder for the P6 pipeline's EX stage. Consumes the controller's start, operation, mthi and mtlo strobes together with the forwarded rs/rt operands. Runs fixed-latency signed and unsigned multiply and divide, and holds the architectural HI/LO registers. Reports `busy` so hazard logic can stall any later multiply/divide instruction until the result is committed.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for mult/multu.
- `DIV_CYCLES`, default 10: busy cycles for div/divu.

Ports:
- `clk` (in, 1): single clock; all state is updated on the rising edge.
- `reset` (in, 1): asynchronous, active-high; clears all state.
- `start` (in, 1): launch the operation selected by `op`. This is the controller's MULT_DIV_START.
- `op` (in, 3): operation select, meaningful only when `start`=1.
  - 3'b000 = mult
  - 3'b001 = multu
  - 3'b010 = div
  - 3'b011 = divu
  - 3'b100–3'b111 are reserved.
- `mthi` (in, 1): write `a` to HI.
- `mtlo` (in, 1): write `a` to LO.
- `a` (in, 32): rs value (forwarded).
- `b` (in, 32): rt value (forwarded).
- `busy` (out, 1): operation in flight. Registered output.
- `hi` (out, 32): architectural HI; the mfhi source.
- `lo` (out, 32): architectural LO; the mflo source.

## Operation
- States:
  - IDLE (`busy`=0).
  - RUN (`busy`=1, down-counter `cnt` active).
- IDLE, `start`=1 with a valid `op`:
  - Latch `a`, `b` and `op`.
  - Load `cnt` with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN.
- IDLE, `start`=1 with a reserved `op`: ignored. No state change, `busy` stays 0.
- RUN: decrement `cnt` every cycle. On the edge where `cnt`=1:
  - Write the result to HI/LO.
  - Set `busy`=0 and go to IDLE.
- Multiply results:
  - mult: {HI,LO} = signed(a)×signed(b), 64-bit.
  - multu: {HI,LO} = unsigned(a)×unsigned(b), 64-bit.
- Divide results:
  - div: LO = signed quotient, truncated toward zero. HI = remainder, which takes the sign of the dividend.
  - div, 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0 (wrap-around, no trap).
  - divu: LO = a/b, HI = a%b, both unsigned.
- Divide by zero (div or divu with latched `b`=0):
  - The full DIV_CYCLES busy period still runs.
  - HI/LO are left unchanged at completion.
- `start` while `busy`=1: ignored. The in-flight operation and its latched operands are unaffected.
- `mthi`/`mtlo` in IDLE with `start`=0: the written register takes `a` at the edge.
  - `mthi` and `mtlo` together: both HI and LO take `a`.
- `mthi`/`mtlo` are ignored when `busy`=1 or `start`=1. `start` has priority.
- No output is X or Z at any time. `hi`/`lo` show only committed values; partial results are never visible.

## Timing
- Reset values: `busy`=0, `hi`=0, `lo`=0, `cnt`=0, state IDLE.
  - Reset during RUN aborts the operation immediately; the result is never written.
- Cycle numbering: `start` is sampled at edge E0.
  - `busy`=1 from just after E0 through edge E(N−1), where N = MULT_CYCLES or DIV_CYCLES.
  - HI/LO are updated and `busy` falls at edge EN.
  - `hi`/`lo` hold the new values from cycle N onward.
- Back-to-back: a new `start` may be accepted at edge EN, the same edge on which `busy` falls. That `start` uses the just-committed HI/LO context.
- `busy` does not rise in the same cycle `start` is high. External stall logic uses `start | busy`.
- `mthi`/`mtlo` take effect at the next edge, with zero latency. mfhi/mflo read `hi`/`lo` combinationally in the cycle after that edge.

## Test plan
- Reset, then `mthi` with `a`=0x12345678 → `hi`=0x12345678 one edge later; `lo`=0, `busy`=0 throughout.
- mult with `a`=0xFFFFFFFE (−2), `b`=3 → `busy` high for exactly 5 cycles. Then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA.
  - Repeat as multu → `hi`=0x00000002, `lo`=0xFFFFFFFA.
- div with `a`=0xFFFFFFF9 (−7), `b`=2 → `busy` high for 10 cycles. Then `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - 0x80000000 div 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- divu with `b`=0, with prior `hi`=0xAA, `lo`=0xBB → `busy` high for 10 cycles. Then `hi`/`lo` still 0xAA/0xBB.
- Start a mult, then change `a`/`b`, pulse `start` with div, and pulse `mtlo` during RUN → all ignored; the original product is committed at E5.
  - A `start` at E5 is accepted.
- Assert `reset` in the 3rd busy cycle of a div → `busy`, `hi`, `lo` become 0 immediately, and no write follows after `reset` is released.
